// File: rtl/vec_group_seq.sv
`default_nettype none
// ============================================================================
//  Module   : vec_group_seq
//  Purpose  : Vector element-group sequencer. Accepts one vector instruction
//             from ID, expands it into one issue slot per group of LANES
//             elements (group index + active-lane mask), holds the front end
//             for the duration and, optionally, drains EXE/MEM/WB before
//             releasing it, since vector results have no forwarding path.
//  Revision : 1.0  initial release
// ----------------------------------------------------------------------------
//  Parameters
//    LANES      lanes per group, width of lane_mask
//    CNT_W      group counter width, up to 2^CNT_W groups per instruction
//    DRAIN_CYC  post-issue drain cycles (used only with the drain option)
//  Ports
//    clk, rst        clock (rising edge), asynchronous active-high reset
//    issue_valid     ID presents a vector instruction
//    issue_ready     sequencer can accept (IDLE and no flush)
//    vlen            element count, sampled at accept
//    flush           branch taken: abort the current sequence
//    cnt             current group index (registered)
//    lane_mask       active lanes of the current group (registered)
//    grp_valid       a group slot is issued this cycle (registered)
//    last            current group is the final one (registered)
//    stall           hold PC and IF/ID (combinational)
//    done            one-cycle pulse when an instruction retires
//    vlen_ovf        sticky: an oversized vlen was clamped
//  Configuration
//    VEC_GROUP_SEQ_DRAIN_EN  defined: DRAIN state between last group and
//                            IDLE; undefined: return to IDLE directly.
// ============================================================================
module vec_group_seq #(
    parameter int LANES     = 8,
    parameter int CNT_W     = 5,
    parameter int DRAIN_CYC = 3
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             issue_valid,
    output logic             issue_ready,
    input  logic [31:0]      vlen,
    input  logic             flush,
    output logic [CNT_W-1:0] cnt,
    output logic [LANES-1:0] lane_mask,
    output logic             grp_valid,
    output logic             last,
    output logic             stall,
    output logic             done,
    output logic             vlen_ovf
);

`ifdef VEC_GROUP_SEQ_DRAIN_EN
    localparam bit DRAIN_EN = 1'b1;
`else
    localparam bit DRAIN_EN = 1'b0;
`endif
    // With the option off (or zero drain cycles) DRAIN is unreachable and
    // its counter is constant, so both disappear in synthesis.
    localparam bit HAS_DRAIN = DRAIN_EN && (DRAIN_CYC > 0);

    localparam int RW  = (LANES > 1) ? $clog2(LANES) : 1;
    localparam int DRW = (DRAIN_CYC > 1) ? $clog2(DRAIN_CYC) : 1;
    localparam logic [31:0]    VLEN_MAX  = 32'(LANES) << CNT_W;
    localparam logic [DRW-1:0] DRAIN_LD  = DRW'(DRAIN_CYC - 1);

    typedef enum logic [1:0] {
        ST_IDLE  = 2'd0,
        ST_RUN   = 2'd1,
        ST_DRAIN = 2'd2
    } state_t;

    state_t           state_q, state_d;
    logic [CNT_W-1:0] cnt_q, cnt_d;
    logic [LANES-1:0] lane_mask_q, lane_mask_d;
    logic             grp_valid_q, grp_valid_d;
    logic             last_q, last_d;
    logic             done_q, done_d;
    logic             vlen_ovf_q, vlen_ovf_d;
    logic [DRW-1:0]   drain_q, drain_d;
    logic [CNT_W-1:0] last_idx_q, last_idx_d;   // index of the final group
    logic [RW-1:0]    rem_q, rem_d;             // occupied lanes of final group

    logic             accept;
    logic [31:0]      vlen_clamp;
    logic [CNT_W-1:0] acc_last_idx;
    logic [RW-1:0]    acc_rem;
    logic [CNT_W-1:0] cnt_inc;

    // Only the final group can be partial; a zero remainder means it is full.
    function automatic logic [LANES-1:0] f_mask(input logic is_last,
                                                input logic [RW-1:0] r);
        if (is_last && (r != '0)) begin
            return ~({LANES{1'b1}} << r);
        end
        return '1;
    endfunction

    assign issue_ready = (state_q == ST_IDLE) && !flush;
    assign accept      = issue_valid && issue_ready;
    assign stall       = (state_q != ST_IDLE) || (accept && (vlen != 32'd0));

    // Geometry of the presented instruction, after clamping to the counter range.
    assign vlen_clamp   = (vlen > VLEN_MAX) ? VLEN_MAX : vlen;
    assign acc_last_idx = (vlen_clamp == 32'd0) ? '0
                        : CNT_W'((vlen_clamp - 32'd1) / 32'(LANES));
    assign acc_rem      = RW'(vlen_clamp % 32'(LANES));
    assign cnt_inc      = cnt_q + 1'b1;

    always_comb begin
        state_d     = state_q;
        cnt_d       = cnt_q;
        lane_mask_d = lane_mask_q;
        grp_valid_d = grp_valid_q;
        last_d      = last_q;
        done_d      = 1'b0;
        vlen_ovf_d  = vlen_ovf_q;
        drain_d     = drain_q;
        last_idx_d  = last_idx_q;
        rem_d       = rem_q;

        case (state_q)
            ST_IDLE: begin
                cnt_d       = '0;
                lane_mask_d = '0;
                grp_valid_d = 1'b0;
                last_d      = 1'b0;
                if (accept) begin
                    if (vlen > VLEN_MAX) begin
                        vlen_ovf_d = 1'b1;
                    end
                    if (vlen == 32'd0) begin
                        done_d = 1'b1;      // empty instruction retires at once
                    end else begin
                        state_d     = ST_RUN;
                        grp_valid_d = 1'b1;
                        last_d      = (acc_last_idx == '0);
                        lane_mask_d = f_mask(acc_last_idx == '0, acc_rem);
                        last_idx_d  = acc_last_idx;
                        rem_d       = acc_rem;
                    end
                end
            end

            ST_RUN: begin
                if (flush) begin
                    state_d     = ST_IDLE;
                    cnt_d       = '0;
                    lane_mask_d = '0;
                    grp_valid_d = 1'b0;
                    last_d      = 1'b0;
                end else if (last_q) begin
                    // cnt keeps the final index while draining
                    grp_valid_d = 1'b0;
                    last_d      = 1'b0;
                    lane_mask_d = '0;
                    if (HAS_DRAIN) begin
                        state_d = ST_DRAIN;
                        drain_d = DRAIN_LD;
                    end else begin
                        state_d = ST_IDLE;
                        cnt_d   = '0;
                        done_d  = 1'b1;
                    end
                end else begin
                    cnt_d       = cnt_inc;
                    grp_valid_d = 1'b1;
                    last_d      = (cnt_inc == last_idx_q);
                    lane_mask_d = f_mask(cnt_inc == last_idx_q, rem_q);
                end
            end

            ST_DRAIN: begin
                if (flush) begin
                    state_d = ST_IDLE;
                    cnt_d   = '0;
                    drain_d = '0;
                end else if (drain_q == '0) begin
                    state_d = ST_IDLE;
                    cnt_d   = '0;
                    done_d  = 1'b1;
                end else begin
                    drain_d = drain_q - 1'b1;
                end
            end

            default: begin
                state_d = ST_IDLE;
            end
        endcase
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q     <= ST_IDLE;
            cnt_q       <= '0;
            lane_mask_q <= '0;
            grp_valid_q <= 1'b0;
            last_q      <= 1'b0;
            done_q      <= 1'b0;
            vlen_ovf_q  <= 1'b0;
            drain_q     <= '0;
            last_idx_q  <= '0;
            rem_q       <= '0;
        end else begin
            state_q     <= state_d;
            cnt_q       <= cnt_d;
            lane_mask_q <= lane_mask_d;
            grp_valid_q <= grp_valid_d;
            last_q      <= last_d;
            done_q      <= done_d;
            vlen_ovf_q  <= vlen_ovf_d;
            drain_q     <= drain_d;
            last_idx_q  <= last_idx_d;
            rem_q       <= rem_d;
        end
    end

    assign cnt       = cnt_q;
    assign lane_mask = lane_mask_q;
    assign grp_valid = grp_valid_q;
    assign last      = last_q;
    assign done      = done_q;
    assign vlen_ovf  = vlen_ovf_q;

endmodule
`default_nettype wire

// File: tb/tb_vec_group_seq.sv
`default_nettype none
// ============================================================================
//  Module   : tb_vec_group_seq
//  Purpose  : Self-checking bench for vec_group_seq. Expected group slots are
//             queued when an instruction is presented and compared as the
//             sequencer issues them; timing of stall/done is checked inline.
//  Revision : 1.0  initial release
// ============================================================================
module tb_vec_group_seq;

`ifdef VEC_GROUP_SEQ_DRAIN_EN
    localparam int D = 3;
`else
    localparam int D = 0;
`endif

    logic        clk = 1'b0;
    logic        rst;
    logic        issue_valid;
    logic        issue_ready;
    logic [31:0] vlen;
    logic        flush;
    logic [4:0]  cnt;
    logic [7:0]  lane_mask;
    logic        grp_valid;
    logic        last;
    logic        stall;
    logic        done;
    logic        vlen_ovf;

    typedef struct packed {
        logic [4:0] cnt;
        logic [7:0] mask;
        logic       last;
    } grp_t;

    grp_t exp_q[$];
    int   n_checks = 0;
    int   n_errors = 0;
    logic exp_ovf  = 1'b0;

    vec_group_seq #(
        .LANES     (8),
        .CNT_W     (5),
        .DRAIN_CYC (3)
    ) u_dut (
        .clk         (clk),
        .rst         (rst),
        .issue_valid (issue_valid),
        .issue_ready (issue_ready),
        .vlen        (vlen),
        .flush       (flush),
        .cnt         (cnt),
        .lane_mask   (lane_mask),
        .grp_valid   (grp_valid),
        .last        (last),
        .stall       (stall),
        .done        (done),
        .vlen_ovf    (vlen_ovf)
    );

    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_errors++;
            $display("FAIL %s: got %0h expected %0h", tag, got, exp);
        end
    endtask

    // Push the slots an instruction of v elements should produce.
    task automatic push_groups(input int v, input int first, input int count);
        int   vc;
        int   g;
        int   r;
        grp_t e;
        vc = (v > 256) ? 256 : v;
        g  = (vc + 7) / 8;
        r  = vc % 8;
        for (int k = first; k < first + count && k < g; k++) begin
            e.cnt  = 5'(k);
            e.mask = (k == g - 1 && r != 0) ? 8'((1 << r) - 1) : 8'hFF;
            e.last = (k == g - 1);
            exp_q.push_back(e);
        end
    endtask

    // Scoreboard side: every issued slot must match the head of the queue.
    always @(negedge clk) begin
        if (!rst && grp_valid === 1'b1) begin
            if (exp_q.size() == 0) begin
                chk("unexpected_grp", 32'(cnt), 32'hFFFF_FFFF);
            end else begin
                grp_t e;
                e = exp_q.pop_front();
                chk("grp_cnt",  32'(cnt),       32'(e.cnt));
                chk("grp_mask", 32'(lane_mask), 32'(e.mask));
                chk("grp_last", 32'(last),      32'(e.last));
            end
        end
    end

    // Called at posedge+4 (or posedge+1); presents v and follows the
    // instruction to its done cycle, returning at posedge+4 of that cycle.
    task automatic run_instr(input int v);
        int vc;
        int g;
        vc = (v > 256) ? 256 : v;
        g  = (vc + 7) / 8;
        push_groups(v, 0, g);
        issue_valid = 1'b1;
        vlen        = 32'(v);
        #3;
        chk("acc_ready", 32'(issue_ready), 32'd1);
        chk("acc_stall", 32'(stall), 32'(v != 0));
        @(posedge clk); #1;
        issue_valid = 1'b0;
        vlen        = $urandom;
        if (v > 256) exp_ovf = 1'b1;
        for (int k = 0; k < g; k++) begin
            if (k > 0) begin @(posedge clk); #1; end
            #3;
            chk("run_grp_valid", 32'(grp_valid), 32'd1);
            chk("run_stall", 32'(stall), 32'd1);
        end
        if (g > 0) begin
            for (int k = 0; k < D; k++) begin
                @(posedge clk); #4;
                chk("drain_grp_valid", 32'(grp_valid), 32'd0);
                chk("drain_stall", 32'(stall), 32'd1);
                chk("drain_done", 32'(done), 32'd0);
                chk("drain_cnt", 32'(cnt), 32'(g - 1));
            end
            @(posedge clk); #4;
        end else begin
            #3;
        end
        chk("done_pulse", 32'(done), 32'd1);
        chk("done_stall", 32'(stall), 32'd0);
        chk("done_cnt", 32'(cnt), 32'd0);
        chk("done_grp_valid", 32'(grp_valid), 32'd0);
        chk("done_ovf", 32'(vlen_ovf), 32'(exp_ovf));
    endtask

    task automatic idle(input int n);
        repeat (n) begin
            @(posedge clk); #4;
            chk("idle_done", 32'(done), 32'd0);
            chk("idle_grp_valid", 32'(grp_valid), 32'd0);
            chk("idle_stall", 32'(stall), 32'd0);
        end
    endtask

    initial begin
        #1_000_000;
        $display("FAIL watchdog: got timeout expected completion");
        $fatal(1, "watchdog expired");
    end

    initial begin
        rst         = 1'b1;
        issue_valid = 1'b0;
        vlen        = 32'd0;
        flush       = 1'b0;
        repeat (2) @(posedge clk);
        #4;
        chk("rst_cnt", 32'(cnt), 32'd0);
        chk("rst_mask", 32'(lane_mask), 32'd0);
        chk("rst_grp_valid", 32'(grp_valid), 32'd0);
        chk("rst_last", 32'(last), 32'd0);
        chk("rst_done", 32'(done), 32'd0);
        chk("rst_ovf", 32'(vlen_ovf), 32'd0);
        chk("rst_stall", 32'(stall), 32'd0);
        chk("rst_ready", 32'(issue_ready), 32'd1);
        @(posedge clk); #1;
        rst = 1'b0;
        idle(2);

        // Partial final group, empty instruction, back-to-back accepts.
        run_instr(20);
        idle(2);
        run_instr(0);
        idle(1);
        run_instr(8);
        run_instr(8);
        run_instr(20);
        run_instr(13);
        idle(1);

        // Oversized vlen: clamped to 32 full groups, sticky overflow flag.
        run_instr(300);
        idle(1);
        run_instr(5);
        chk("ovf_sticky", 32'(vlen_ovf), 32'd1);
        idle(1);

        // Flush while idle blocks the accept.
        flush       = 1'b1;
        issue_valid = 1'b1;
        vlen        = 32'd8;
        #2;
        chk("flush_idle_ready", 32'(issue_ready), 32'd0);
        chk("flush_idle_stall", 32'(stall), 32'd0);
        @(posedge clk); #1;
        flush       = 1'b0;
        issue_valid = 1'b0;
        #3;
        chk("flush_idle_grp_valid", 32'(grp_valid), 32'd0);
        chk("flush_idle_done", 32'(done), 32'd0);

        // Flush mid-run during cnt=1, then a normal accept right after.
        push_groups(16, 0, 2);
        issue_valid = 1'b1;
        vlen        = 32'd16;
        #3;
        @(posedge clk); #1;
        issue_valid = 1'b0;
        @(posedge clk); #1;
        flush = 1'b1;
        #3;
        chk("flush_run_stall", 32'(stall), 32'd1);
        chk("flush_run_cnt", 32'(cnt), 32'd1);
        @(posedge clk); #1;
        flush = 1'b0;
        #3;
        chk("flush_grp_valid", 32'(grp_valid), 32'd0);
        chk("flush_cnt", 32'(cnt), 32'd0);
        chk("flush_mask", 32'(lane_mask), 32'd0);
        chk("flush_last", 32'(last), 32'd0);
        chk("flush_done", 32'(done), 32'd0);
        chk("flush_stall", 32'(stall), 32'd0);
        run_instr(8);
        idle(1);

        // Asynchronous reset while cnt=3 of a 64-element instruction.
        push_groups(64, 0, 4);
        issue_valid = 1'b1;
        vlen        = 32'd64;
        #3;
        @(posedge clk); #1;
        issue_valid = 1'b0;
        repeat (3) @(posedge clk);
        #7;
        chk("pre_rst_cnt", 32'(cnt), 32'd3);
        rst = 1'b1;
        #1;
        chk("arst_cnt", 32'(cnt), 32'd0);
        chk("arst_mask", 32'(lane_mask), 32'd0);
        chk("arst_grp_valid", 32'(grp_valid), 32'd0);
        chk("arst_last", 32'(last), 32'd0);
        chk("arst_ovf", 32'(vlen_ovf), 32'd0);
        exp_ovf = 1'b0;
        repeat (2) @(posedge clk);
        #1;
        rst = 1'b0;
        idle(8);
        run_instr(9);
        idle(1);

        chk("queue_empty", 32'(exp_q.size()), 32'd0);
        $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
        $finish;
    end

endmodule
`default_nettype wire

// File: doc/vec_group_seq.md
# vec_group_seq

Vector element-group sequencer for the 5-stage vector pipeline. It accepts one vector instruction at a time from the ID stage and expands it into per-group issue slots. Each slot drives the 5-bit group counter (`cnt`) and an 8-lane active mask into ID/EXE. It stalls the PC and IF/ID for the duration and drains the pipeline before releasing the front end, because vector results have no forwarding path.

## Interface
- `LANES`, default 8: lanes per group; lane_mask width.
- `CNT_W`, default 5: group counter width; maximum groups = 2^CNT_W = 32.
- `DRAIN_CYC`, default 3: post-issue drain cycles, covering EXE/MEM/WB.

Ports:
- `clk`  in  1: clock, rising edge.
- `rst`  in  1: asynchronous, active-high reset.
- `issue_valid`  in  1: ID holds a vector instruction.
- `issue_ready`  out  1: sequencer can accept; combinational = (state==IDLE) & !flush.
- `vlen`  in  32: element count of the presented instruction; sampled only at accept.
- `flush`  in  1: branch taken (PCSrc); aborts the current sequence.
- `cnt`  out  CNT_W: current group index (registered).
- `lane_mask`  out  LANES: active lanes of current group (registered).
- `grp_valid`  out  1: a group slot is issued this cycle (registered).
- `last`  out  1: current group is the final one (registered).
- `stall`  out  1: hold PC and IF/ID (combinational).
- `done`  out  1: one-cycle pulse when an instruction fully retires (registered).
- `vlen_ovf`  out  1: sticky; a vlen > LANES·2^CNT_W was clamped.

## Operation
- States: IDLE, RUN, DRAIN.
- Accept: issue_valid & issue_ready at a rising edge.
- Group count G = ceil(vlen/LANES), clamped to 32.
- Remainder R = vlen mod LANES, computed on the clamped vlen.
- vlen is latched at accept.
- IDLE, accept with vlen==0: stay IDLE. done pulses next cycle. No groups.
- IDLE, accept with vlen>0: go to RUN. Next cycle cnt=0, grp_valid=1.
- vlen > 256: clamp to 256 (G=32, R=0) and set vlen_ovf. vlen_ovf clears only on rst.
- RUN: one group per cycle; cnt increments 0..G-1.
  - lane_mask = all ones, except on the final group when R≠0: lane_mask = (1<<R)-1.
  - last=1 on the final group only.
  - After the final group: go to DRAIN; grp_valid, last and lane_mask drop to 0; cnt holds.
- DRAIN: count down DRAIN_CYC cycles, then go to IDLE. done=1 for one cycle in the first IDLE cycle. cnt resets to 0 there.
- stall = (state≠IDLE) | (issue_valid & vlen≠0 & issue_ready).
- flush in RUN or DRAIN: at the next edge go to IDLE.
  - cnt=0, lane_mask=0, grp_valid=0, last=0.
  - No done pulse.
  - Slots already issued are the downstream pipeline's responsibility.
- flush in IDLE: issue_ready=0, so no accept that cycle.
- A new accept is allowed in the same cycle done is high.
- Reset: state IDLE; cnt=0, lane_mask=0, grp_valid=0, last=0, done=0, vlen_ovf=0. The drain counter is 0.

## Timing
- Accept at edge T.
- Groups are visible in cycles T+1 .. T+G.
- DRAIN occupies T+G+1 .. T+G+DRAIN_CYC.
- done is high in T+G+DRAIN_CYC+1.
- Total front-end stall = G+DRAIN_CYC+1 cycles, counting the accept cycle.
- A single-group instruction (vlen 1..8) has grp_valid for exactly one cycle, with last=1.
- Back-to-back accepts have a minimum spacing of G+DRAIN_CYC+1 cycles.
- Asserting rst mid-RUN returns all outputs to reset values immediately (asynchronous). Sequencing restarts only on a new accept after rst deasserts.

## Configuration
- Macro `VEC_GROUP_SEQ_DRAIN_EN`.
- Defined: DRAIN state present, as described above.
- Undefined: DRAIN is removed.
  - After the final group the sequencer goes directly to IDLE.
  - done is high in T+G+1.
  - Stall is G+1 cycles.
  - The DRAIN_CYC parameter is ignored.

## Test plan
- vlen=20 accept at T → cnt 0,1,2 in T+1..T+3; lane_mask FF,FF,0F; last only at T+3; DRAIN T+4..T+6; done at T+7; stall high T..T+6.
- vlen=0 accept → no grp_valid; done one cycle later; stall never high.
- vlen=300 → G=32, cnt 0..31, final lane_mask FF, vlen_ovf=1 and sticky until rst.
- vlen=16, flush during cnt=1 → next cycle IDLE, grp_valid=0, no done; a new accept of vlen=8 the following cycle works normally.
- rst asserted mid-RUN (vlen=64, cnt=3) → cnt, lane_mask, grp_valid and last go to 0 asynchronously; no done after release.
- Without `VEC_GROUP_SEQ_DRAIN_EN`: vlen=8 accept at T → grp_valid/last at T+1, done at T+2; back-to-back accept at T+2 is accepted.
